controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 Port: opcode  input  3  current instruction opcode from the instruction register; encoding HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111 (same encoding the ALU uses).
REQ-004 Port: zero  input  1  accumulator-zero flag from ALU is_zero.
REQ-005 Port: sel  output  1  address mux select; 1=PC, 0=IR operand address.
REQ-006 Port: rd  output  1  memory read enable.
REQ-007 Port: ld_ir  output  1  instruction register load enable.
REQ-008 Port: inc_pc  output  1  program counter increment.
REQ-009 Port: ld_pc  output  1  program counter load (jump).
REQ-010 Port: ld_ac  output  1  accumulator load from ALU result.
REQ-011 Port: wr  output  1  memory write strobe.
REQ-012 Port: data_e  output  1  accumulator drive enable onto data bus.
REQ-013 Port: halt  output  1  CPU halted indicator.
REQ-014 Port: phase  output  3  current phase index, 0-7 (7 also while halted).

Function
REQ-015 State machine SHALL have nine states: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED.
REQ-016 States 0-7 SHALL advance one state per clock, with STORE wrapping to INST_ADDR; one instruction = exactly 8 cycles.
REQ-017 In OP_ADDR with opcode=HLT, next state SHALL be HALTED instead of OP_FETCH.
REQ-018 HALTED SHALL be absorbing: stays until rst_n asserted, regardless of opcode/zero.
REQ-019 All outputs SHALL be combinational (Moore on state, plus opcode/zero where listed); ALUOP denotes opcode in {ADD, AND, XOR, LDA}.
REQ-020 sel SHALL be 1 in states 0-3, 0 elsewhere.
REQ-021 rd SHALL be 1 in states 1-3; equal to ALUOP in states 5-7; 0 elsewhere.
REQ-022 ld_ir SHALL be 1 in states 2-3 only.
REQ-023 inc_pc SHALL be 1 in OP_ADDR when opcode!=HLT, and 1 in ALU_OP when opcode=SKZ and zero=1; 0 elsewhere (PC advances twice on a taken skip).
REQ-024 ld_pc SHALL equal (opcode==JMP) in states 6-7; 0 elsewhere.
REQ-025 ld_ac SHALL equal ALUOP in STORE only.
REQ-026 data_e SHALL equal (opcode==STO) in states 6-7; wr SHALL equal (opcode==STO) in STORE only.
REQ-027 halt SHALL be 1 in OP_ADDR when opcode=HLT and in HALTED; 0 elsewhere.
REQ-028 In HALTED all outputs except halt SHALL be 0; phase SHALL read 7.
REQ-029 zero SHALL only affect outputs in ALU_OP; opcode changes outside states 3-7 SHALL have no effect on state.
REQ-030 wr and rd SHALL never be 1 in the same cycle; ld_pc and inc_pc SHALL never be 1 together.

Reset
REQ-031 rst_n=0 SHALL force INST_ADDR immediately (asynchronous), from any state including HALTED and mid-instruction.
REQ-032 Reset output values: sel=1, phase=0, all other outputs 0.
REQ-033 After rst_n deasserts, first rising edge SHALL move to INST_FETCH.

Verification
REQ-034 Reset: assert rst_n=0 in ALU_OP of a STO -> same timestep sel=1, phase=0, wr=0, data_e=0; after release, phase 1 on next edge.
REQ-035 ADD (opcode=010): rd=1 phases 1,2,3,5,6,7; ld_ir phases 2,3; inc_pc phase 4 only; ld_ac phase 7 only; wr/data_e/ld_pc never.
REQ-036 SKZ: zero=1 -> inc_pc in phases 4 and 6; zero=0 -> inc_pc phase 4 only; rd=0 phases 5-7 in both.
REQ-037 JMP (111): ld_pc=1 phases 6,7; inc_pc phase 4 only; ld_ac=0 throughout.
REQ-038 STO (110): data_e=1 phases 6,7; wr=1 phase 7 only; rd=0 phases 5-7; ld_ac=0.
REQ-039 HLT (000): halt=1 in phase 4, then HALTED with halt=1, phase=7, all else 0 for 20 cycles under random opcode/zero; rst_n pulse returns to phase 0.

Source files
------------

// File: rtl/controller_if.sv
// rtl/controller_if.sv - opcode/flag inputs and control strobes between the sequencer and the datapath
interface controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       wr;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );
endinterface

// File: rtl/controller.sv
// rtl/controller.sv - eight-phase instruction sequencer with an absorbing halt state
module controller (
  input  logic         clk,
  input  logic         rst_n,
  controller_if.master bus
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_e state_q, state_d;
  logic   alu_op;
  logic   is_hlt, is_sto, is_jmp, is_skz;

  assign alu_op = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
  assign is_hlt = (bus.opcode == OP_HLT);
  assign is_sto = (bus.opcode == OP_STO);
  assign is_jmp = (bus.opcode == OP_JMP);
  assign is_skz = (bus.opcode == OP_SKZ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INST_ADDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = is_hlt ? HALTED : OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      HALTED:     state_d = HALTED;
      default:    state_d = INST_ADDR;
    endcase
  end

  // Outputs decode from the current state only, plus opcode/zero in the operand phases.
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    bus.phase  = state_q[2:0];
    case (state_q)
      INST_ADDR:  bus.sel = 1'b1;
      INST_FETCH: begin
        bus.sel = 1'b1;
        bus.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        bus.sel   = 1'b1;
        bus.rd    = 1'b1;
        bus.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        bus.inc_pc = !is_hlt;
        bus.halt   = is_hlt;
      end
      OP_FETCH:   bus.rd = alu_op;
      ALU_OP: begin
        bus.rd     = alu_op;
        bus.inc_pc = is_skz && bus.zero;
        bus.ld_pc  = is_jmp;
        bus.data_e = is_sto;
      end
      STORE: begin
        bus.rd     = alu_op;
        bus.ld_ac  = alu_op;
        bus.ld_pc  = is_jmp;
        bus.data_e = is_sto;
        bus.wr     = is_sto;
      end
      HALTED: begin
        bus.halt  = 1'b1;
        bus.phase = 3'd7;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - directed per-phase checks of the instruction sequencer
module tb_controller;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  controller_if bus ();

  controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  function automatic logic [8:0] outs();
    return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
            bus.ld_ac, bus.wr, bus.data_e, bus.halt};
  endfunction

  typedef struct {
    string           name;
    logic [2:0]      opcode;
    logic            zero;
    logic [7:0][8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic [2:0] op, input logic z,
                         input logic [8:0] p5, input logic [8:0] p6, input logic [8:0] p7);
    vec_t v;
    v.name   = name;
    v.opcode = op;
    v.zero   = z;
    v.exp    = {p7, p6, p5, 9'h020, 9'h1C0, 9'h1C0, 9'h180, 9'h100};
    vecs.push_back(v);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((bus.wr && bus.rd) || (bus.ld_pc && bus.inc_pc)) begin
        errors++;
        $display("FAIL exclusive strobes: wr=%b rd=%b ld_pc=%b inc_pc=%b",
                 bus.wr, bus.rd, bus.ld_pc, bus.inc_pc);
      end
    end
  end

  initial begin
    add_vec("ADD",     3'b010, 1'b0, 9'h080, 9'h080, 9'h088);
    add_vec("ADD z1",  3'b010, 1'b1, 9'h080, 9'h080, 9'h088);
    add_vec("AND",     3'b011, 1'b0, 9'h080, 9'h080, 9'h088);
    add_vec("XOR",     3'b100, 1'b1, 9'h080, 9'h080, 9'h088);
    add_vec("LDA",     3'b101, 1'b0, 9'h080, 9'h080, 9'h088);
    add_vec("SKZ z1",  3'b001, 1'b1, 9'h000, 9'h020, 9'h000);
    add_vec("SKZ z0",  3'b001, 1'b0, 9'h000, 9'h000, 9'h000);
    add_vec("JMP",     3'b111, 1'b0, 9'h000, 9'h010, 9'h010);
    add_vec("JMP z1",  3'b111, 1'b1, 9'h000, 9'h010, 9'h010);
    add_vec("STO",     3'b110, 1'b0, 9'h000, 9'h002, 9'h006);

    rst_n      = 1'b0;
    bus.opcode = 3'b110;
    bus.zero   = 1'b0;
    repeat (3) step();
    check("reset outs", outs(), 9'h100);
    check("reset phase", {6'd0, bus.phase}, 9'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int p = 0; p < 8; p++) begin
        // Opcode is only meaningful once the IR is loaded; park it on HLT earlier.
        bus.opcode = (p < 2) ? 3'b000 : vecs[i].opcode;
        bus.zero   = (p < 2) ? ~vecs[i].zero : vecs[i].zero;
        #1;
        check($sformatf("%s p%0d outs", vecs[i].name, p), outs(), vecs[i].exp[p]);
        check($sformatf("%s p%0d phase", vecs[i].name, p), {6'd0, bus.phase}, 9'(p));
        step();
      end
    end

    // Asynchronous reset in ALU_OP of a STO
    bus.opcode = 3'b110;
    bus.zero   = 1'b0;
    repeat (6) step();
    check("sto p6 before reset", outs(), 9'h002);
    rst_n = 1'b0;
    #1;
    check("async reset outs", outs(), 9'h100);
    check("async reset phase", {6'd0, bus.phase}, 9'd0);
    #2;
    rst_n = 1'b1;
    step();
    check("post reset phase", {6'd0, bus.phase}, 9'd1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    // HLT then absorbing halted state
    bus.opcode = 3'b000;
    bus.zero   = 1'b0;
    #1;
    check("hlt p0 outs", outs(), 9'h100);
    repeat (4) step();
    check("hlt p4 outs", outs(), 9'h001);
    check("hlt p4 phase", {6'd0, bus.phase}, 9'd4);
    step();
    for (int c = 0; c < 20; c++) begin
      bus.opcode = 3'($urandom_range(0, 7));
      bus.zero   = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halted c%0d outs", c), outs(), 9'h001);
      check($sformatf("halted c%0d phase", c), {6'd0, bus.phase}, 9'd7);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("halt reset outs", outs(), 9'h100);
    check("halt reset phase", {6'd0, bus.phase}, 9'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("halt release phase", {6'd0, bus.phase}, 9'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
